tmds_channel_decoder: RTL and testbench

Receive-side counterpart of the TMDS channel encoder inside `hdmi`. Takes unaligned 10-bit parallel words from an external 10:1 deserializer (one word per `clk_pixel`), finds symbol alignment by hunting for control tokens, and decodes each aligned symbol as video data, control period (C1:C0) or TERC4 data-island nibble. One instance per TMDS data channel (0–2); a sink top instantiates three and ANDs their `locked` outputs.

---
 rtl/tmds_channel_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tmds_channel_decoder
// Brief    : One TMDS data channel. It finds symbol alignment from control
//            tokens, then decodes each aligned symbol as video, control or
//            TERC4 data.
// Revision : 1.0 - initial release
// ============================================================================
module tmds_channel_decoder #(
    parameter int LOCK_COUNT     = 16,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int LOSS_TIMEOUT   = 65535
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic [9:0] raw,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic [3:0] terc4,
    output logic       is_ctrl,
    output logic       is_terc4,
    output logic       locked,
    output logic [3:0] offset
);

    localparam int c_IDLE_MAX = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT;
    localparam int c_RUN_W    = $clog2(LOCK_COUNT + 1);
    localparam int c_IDLE_W   = $clog2(c_IDLE_MAX + 1);

    localparam logic [c_RUN_W-1:0]  c_LOCK_LIM   = c_RUN_W'(LOCK_COUNT);
    localparam logic [c_IDLE_W-1:0] c_SEARCH_LIM = c_IDLE_W'(SEARCH_TIMEOUT);
    localparam logic [c_IDLE_W-1:0] c_LOSS_LIM   = c_IDLE_W'(LOSS_TIMEOUT);
    localparam logic [c_IDLE_W-1:0] c_IDLE_SAT   = c_IDLE_W'(c_IDLE_MAX);

    typedef enum logic [0:0] {
        S_SEARCH = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t              r_state, w_state_next;
    logic [9:0]          r_raw_q;
    logic [9:0]          r_q;
    logic [3:0]          r_offset, w_offset_next;
    logic [c_RUN_W-1:0]  r_run_cnt, w_run_next, w_run_inc;
    logic [c_IDLE_W-1:0] r_idle_cnt, w_idle_next, w_idle_inc;
    logic [1:0]          r_flush, w_flush_next;

    logic [18:0] w_window;
    logic [9:0]  w_sym;
    logic [7:0]  w_d;
    logic [7:0]  w_data;
    logic [1:0]  w_ctrl;
    logic [3:0]  w_terc4;
    logic        w_is_ctrl;
    logic        w_is_terc4;

    // Offsets only reach 9, so the top bit of the current word never lands in a symbol.
    assign w_window = {raw[8:0], r_raw_q};

    always_comb begin
        w_sym = w_window[9:0];
        for (int k = 1; k < 10; k++) begin
            if (r_offset == 4'(k)) begin
                w_sym = w_window[k +: 10];
            end
        end
    end

    always_comb begin
        w_d       = r_q[9] ? ~r_q[7:0] : r_q[7:0];
        w_data    = '0;
        w_data[0] = w_d[0];
        for (int i = 1; i < 8; i++) begin
            w_data[i] = r_q[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
        end
    end

    always_comb begin
        w_is_ctrl = 1'b1;
        w_ctrl    = 2'b00;
        case (r_q)
            10'b1101010100: w_ctrl = 2'b00;
            10'b0010101011: w_ctrl = 2'b01;
            10'b0101010100: w_ctrl = 2'b10;
            10'b1010101011: w_ctrl = 2'b11;
            default:        w_is_ctrl = 1'b0;
        endcase
    end

    always_comb begin
        w_is_terc4 = 1'b1;
        w_terc4    = 4'h0;
        case (r_q)
            10'b1010011100: w_terc4 = 4'h0;
            10'b1001100011: w_terc4 = 4'h1;
            10'b1011100100: w_terc4 = 4'h2;
            10'b1011100010: w_terc4 = 4'h3;
            10'b0101110001: w_terc4 = 4'h4;
            10'b0100011110: w_terc4 = 4'h5;
            10'b0110001110: w_terc4 = 4'h6;
            10'b0100111100: w_terc4 = 4'h7;
            10'b1011001100: w_terc4 = 4'h8;
            10'b0100111001: w_terc4 = 4'h9;
            10'b0110011100: w_terc4 = 4'hA;
            10'b1011000110: w_terc4 = 4'hB;
            10'b1010001110: w_terc4 = 4'hC;
            10'b1001110001: w_terc4 = 4'hD;
            10'b0101100011: w_terc4 = 4'hE;
            10'b1011000011: w_terc4 = 4'hF;
            default:        w_is_terc4 = 1'b0;
        endcase
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_raw_q  <= '0;
            r_q      <= '0;
            data     <= '0;
            ctrl     <= '0;
            terc4    <= '0;
            is_ctrl  <= 1'b0;
            is_terc4 <= 1'b0;
        end else begin
            r_raw_q  <= raw;
            r_q      <= w_sym;
            data     <= w_data;
            ctrl     <= w_ctrl;
            terc4    <= w_terc4;
            is_ctrl  <= w_is_ctrl;
            is_terc4 <= w_is_terc4;
        end
    end

    assign w_run_inc  = (r_run_cnt == c_LOCK_LIM) ? r_run_cnt : r_run_cnt + 1'b1;
    assign w_idle_inc = (r_idle_cnt == c_IDLE_SAT) ? r_idle_cnt : r_idle_cnt + 1'b1;

    // The FSM watches the registered flags, so a new offset needs two flush cycles.
    always_comb begin
        w_state_next  = r_state;
        w_run_next    = r_run_cnt;
        w_idle_next   = r_idle_cnt;
        w_offset_next = r_offset;
        w_flush_next  = r_flush;
        case (r_state)
            S_SEARCH: begin
                if (r_flush != 2'd0) begin
                    w_flush_next = r_flush - 2'd1;
                end else if (is_ctrl) begin
                    w_idle_next = '0;
                    w_run_next  = w_run_inc;
                    if (w_run_inc == c_LOCK_LIM) begin
                        w_state_next = S_LOCKED;
                        w_run_next   = '0;
                    end
                end else begin
                    w_run_next  = '0;
                    w_idle_next = w_idle_inc;
                    if (w_idle_inc == c_SEARCH_LIM) begin
                        w_offset_next = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
                        w_idle_next   = '0;
                        w_flush_next  = 2'd2;
                    end
                end
            end
            S_LOCKED: begin
                if (is_ctrl) begin
                    w_idle_next = '0;
                end else begin
                    w_idle_next = w_idle_inc;
                    if (w_idle_inc == c_LOSS_LIM) begin
                        w_state_next = S_SEARCH;
                        w_idle_next  = '0;
                        w_run_next   = '0;
                    end
                end
            end
            default: w_state_next = S_SEARCH;
        endcase
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_state    <= S_SEARCH;
            r_offset   <= '0;
            r_run_cnt  <= '0;
            r_idle_cnt <= '0;
            r_flush    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_offset   <= w_offset_next;
            r_run_cnt  <= w_run_next;
            r_idle_cnt <= w_idle_next;
            r_flush    <= w_flush_next;
        end
    end

    assign locked = (r_state == S_LOCKED);
    assign offset = r_offset;

endmodule
`default_nettype wire

// File: tb/tb_tmds_channel_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tmds_channel_decoder
// Brief    : Directed self-checking bench for tmds_channel_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tmds_channel_decoder;

    logic       clk_pixel = 1'b0;
    logic       reset     = 1'b1;
    logic [9:0] raw       = '0;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic [3:0] terc4;
    logic       is_ctrl;
    logic       is_terc4;
    logic       locked;
    logic [3:0] offset;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [9:0] c_T00 = 10'b1101010100;
    localparam logic [9:0] c_T01 = 10'b0010101011;
    localparam logic [9:0] c_T10 = 10'b0101010100;
    localparam logic [9:0] c_T11 = 10'b1010101011;
    localparam logic [9:0] c_VID = 10'b0100000000;

    always #5 clk_pixel = ~clk_pixel;

    tmds_channel_decoder #(
        .LOCK_COUNT    (16),
        .SEARCH_TIMEOUT(8),
        .LOSS_TIMEOUT  (32)
    ) dut (
        .clk_pixel(clk_pixel),
        .reset    (reset),
        .raw      (raw),
        .data     (data),
        .ctrl     (ctrl),
        .terc4    (terc4),
        .is_ctrl  (is_ctrl),
        .is_terc4 (is_terc4),
        .locked   (locked),
        .offset   (offset)
    );

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        raw   = '0;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        raw   = 10'b1101010100;
        repeat (3) tick();
        n_tests++;
        if ({data, ctrl, terc4, is_ctrl, is_terc4, locked, offset} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_values got data=%h ctrl=%b terc4=%h is_ctrl=%b is_terc4=%b locked=%b offset=%0d expected all zero",
                     data, ctrl, terc4, is_ctrl, is_terc4, locked, offset);
        end
        reset = 1'b0;
    endtask

    task automatic test_aligned_ctrl();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            raw = c_T00;
            tick();
            if (k == 1) begin
                n_tests++;
                if (is_ctrl !== 1'b0) begin
                    n_fail++;
                    $display("FAIL aligned_latency k=%0d is_ctrl=%b expected 0", k, is_ctrl);
                end
            end
            if (k >= 2) begin
                n_tests++;
                if (is_ctrl !== 1'b1 || ctrl !== 2'b00) begin
                    n_fail++;
                    $display("FAIL aligned_ctrl k=%0d is_ctrl=%b ctrl=%b expected 1 00", k, is_ctrl, ctrl);
                end
            end
            if (k == 17 || k == 18) begin
                n_tests++;
                if (locked !== (k == 18)) begin
                    n_fail++;
                    $display("FAIL aligned_lock k=%0d locked=%b expected %b", k, locked, (k == 18));
                end
            end
        end
        n_tests++;
        if (offset !== 4'd0) begin
            n_fail++;
            $display("FAIL aligned_offset offset=%0d expected 0", offset);
        end
    endtask

    task automatic test_video();
        logic [9:0] sym [4];
        logic [7:0] exp_b [4];
        sym   = '{10'b0100000000, 10'b1111001100, 10'b0101100001, 10'b1000000000};
        exp_b = '{8'h00, 8'h55, 8'hA3, 8'hFF};
        for (int k = 0; k < 8; k++) begin
            raw = (k < 4) ? sym[k] : c_T00;
            tick();
            if (k == 1) begin
                n_tests++;
                if (is_ctrl !== 1'b1) begin
                    n_fail++;
                    $display("FAIL video_latency is_ctrl=%b expected 1", is_ctrl);
                end
            end
            if (k >= 2 && k < 6) begin
                n_tests++;
                if (data !== exp_b[k-2] || is_ctrl !== 1'b0 || is_terc4 !== 1'b0 || ctrl !== 2'b00) begin
                    n_fail++;
                    $display("FAIL video_data idx=%0d data=%h is_ctrl=%b is_terc4=%b ctrl=%b expected %h 0 0 00",
                             k - 2, data, is_ctrl, is_terc4, ctrl, exp_b[k-2]);
                end
            end
        end
    endtask

    task automatic test_ctrl_codes();
        logic [9:0] tok [4];
        tok = '{c_T00, c_T01, c_T10, c_T11};
        for (int k = 0; k < 8; k++) begin
            raw = (k < 4) ? tok[k] : c_T00;
            tick();
            if (k >= 2 && k < 6) begin
                n_tests++;
                if (is_ctrl !== 1'b1 || ctrl !== 2'(k - 2) || is_terc4 !== 1'b0 || terc4 !== 4'h0) begin
                    n_fail++;
                    $display("FAIL ctrl_code idx=%0d is_ctrl=%b ctrl=%b is_terc4=%b terc4=%h expected 1 %0d 0 0",
                             k - 2, is_ctrl, ctrl, is_terc4, terc4, k - 2);
                end
            end
        end
    endtask

    task automatic test_terc4();
        logic [9:0] code [16];
        code = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                 10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                 10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
                 10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
        for (int k = 0; k < 20; k++) begin
            raw = (k < 16) ? code[k] : c_T00;
            tick();
            if (k >= 2 && k < 18) begin
                n_tests++;
                if (is_terc4 !== 1'b1 || terc4 !== 4'(k - 2) || is_ctrl !== 1'b0 || ctrl !== 2'b00 || locked !== 1'b1) begin
                    n_fail++;
                    $display("FAIL terc4 idx=%0d is_terc4=%b terc4=%h is_ctrl=%b ctrl=%b locked=%b expected 1 %h 0 00 1",
                             k - 2, is_terc4, terc4, is_ctrl, ctrl, locked, 4'(k - 2));
                end
            end
        end
    endtask

    task automatic test_loss_of_lock();
        for (int k = 0; k < 38; k++) begin
            raw = (k < 31) ? c_VID : c_T00;
            tick();
            n_tests++;
            if (locked !== 1'b1) begin
                n_fail++;
                $display("FAIL loss_token_saves k=%0d locked=%b expected 1", k, locked);
            end
        end
        for (int k = 0; k < 36; k++) begin
            raw = c_VID;
            tick();
            if (k == 33 || k == 34) begin
                n_tests++;
                if (locked !== (k == 33)) begin
                    n_fail++;
                    $display("FAIL loss_drop k=%0d locked=%b expected %b", k, locked, (k == 33));
                end
            end
        end
        n_tests++;
        if (offset !== 4'd0) begin
            n_fail++;
            $display("FAIL loss_offset offset=%0d expected 0", offset);
        end
    endtask

    task automatic test_misaligned();
        int         lock_t = 0;
        logic [3:0] prev   = 4'd0;
        do_reset();
        raw = 10'b0110010101;
        for (int t = 1; t <= 120; t++) begin
            tick();
            if (offset !== prev) begin
                n_tests++;
                if (offset !== prev + 4'd1) begin
                    n_fail++;
                    $display("FAIL misalign_step t=%0d offset=%0d expected %0d", t, offset, prev + 4'd1);
                end
                prev = offset;
            end
            if (locked === 1'b1 && lock_t == 0) lock_t = t;
        end
        n_tests++;
        if (lock_t != 86) begin
            n_fail++;
            $display("FAIL misalign_lock_cycle got %0d expected 86 (0 means never locked)", lock_t);
        end
        n_tests++;
        if (offset !== 4'd7 || locked !== 1'b1 || is_ctrl !== 1'b1 || ctrl !== 2'b01) begin
            n_fail++;
            $display("FAIL misalign_final offset=%0d locked=%b is_ctrl=%b ctrl=%b expected 7 1 1 01",
                     offset, locked, is_ctrl, ctrl);
        end
    endtask

    task automatic test_offset_wrap();
        do_reset();
        raw = '0;
        for (int t = 1; t <= 98; t++) begin
            tick();
            if (t == 88 || t == 98) begin
                n_tests++;
                if (offset !== ((t == 88) ? 4'd9 : 4'd0)) begin
                    n_fail++;
                    $display("FAIL offset_wrap t=%0d offset=%0d expected %0d", t, offset, (t == 88) ? 9 : 0);
                end
            end
        end
    endtask

    task automatic test_reset_async();
        do_reset();
        raw = '0;
        repeat (48) tick();
        n_tests++;
        if (offset !== 4'd5 || data !== 8'hFE) begin
            n_fail++;
            $display("FAIL async_pre offset=%0d data=%h expected 5 fe", offset, data);
        end
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({data, ctrl, terc4, is_ctrl, is_terc4, locked, offset} !== 21'd0) begin
            n_fail++;
            $display("FAIL async_reset data=%h ctrl=%b terc4=%h is_ctrl=%b is_terc4=%b locked=%b offset=%0d expected all zero",
                     data, ctrl, terc4, is_ctrl, is_terc4, locked, offset);
        end
        tick();
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_aligned_ctrl();
        test_video();
        test_ctrl_codes();
        test_terc4();
        test_loss_of_lock();
        test_misaligned();
        test_offset_wrap();
        test_reset_async();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
